vm_input_conditioner: RTL and testbench
=======================================

// Module: vm_input_conditioner
// PURPOSE
//  Front-end stage that feeds the vending-machine FSM. It takes the 9 raw board inputs (coins, buy buttons, refund)
//  and passes each through a 2-flop synchronizer and a per-channel debouncer. It converts each debounced press
//  into a single-cycle event pulse. At most one event per cycle leaves the block, so the downstream state logic
//  never sees two simultaneous inputs.
// PARAMETERS
//  DB_COUNT  500000  consecutive stable cycles required to accept a level change (5 ms @ 100 MHz); bench uses 4
//  CNT_W     19      debounce counter width; must satisfy 2**CNT_W > DB_COUNT
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  synchronous, active-high reset
//  raw_moneyin    in   4  raw coin switches, async: 1000[3] 500[2] 200[1] 100[0]
//  raw_buy        in   4  raw buy buttons, async: 900[3] 700[2] 500[1] 300[0]
//  raw_refund     in   1  raw refund button, async
//  moneyin        out  4  one-cycle coin event, at most one bit set, to FSM
//  buy            out  4  one-cycle buy event, to FSM
//  refund         out  1  one-cycle refund event, to FSM
//  event_drop     out  1  one-cycle flag: a press was discarded this cycle
//  pending        out  1  1 while undelivered presses are queued (tied 0 without VM_PENDING_EN)
// BEHAVIOUR
//  - Reset: sync flops, debounced levels, counters, pending vector and all outputs -> 0. Reset mid-debounce discards progress.
//  - Channel order: bit8 refund, bits 7..4 moneyin[3..0], bits 3..0 buy[3..0]. Priority descends from bit8 to bit0.
//  - Sync: s = 2nd flop of raw input; no logic between the flops.
//  - Debounce per channel, with stable level lvl and counter cnt:
//      - s==lvl: cnt<=0.
//      - s!=lvl and cnt==DB_COUNT-1: lvl<=s, cnt<=0.
//      - else: cnt<=cnt+1.
//      - Any glitch shorter than DB_COUNT cycles is ignored; the count restarts on every return to lvl.
//  - Press: p[i] = lvl[i] & ~lvl_d[i] (rising edge of lvl only). Release produces no event. Holding a button never repeats.
//  - Latency: count as edge 1 the first clk edge that samples raw high. The output pulse is high in the cycle
//    following edge DB_COUNT+3 (DB_COUNT=4 -> after edge 7).
//  - Outputs are registered. Each pulse is exactly 1 cycle. Output vector {refund,moneyin,buy} is zero or one-hot.
//  - Arbitration: req = p (| pend with EN). Grant the highest-priority set bit; its pulse is registered this edge.
//  - Boundaries:
//      - Simultaneous presses of different channels are arbitrated as above.
//      - A channel pressed again before its first event is delivered is merged and raises event_drop.
//      - reset has priority over all other activity.
// CONFIGURATION
//  VM_PENDING_EN defined:
//  - Ungranted req bits are held in a 9-bit pend register and issued on later cycles, one per cycle, by priority.
//  - pending = |pend.
//  - event_drop fires only on a re-press of a channel already pending.
//  VM_PENDING_EN undefined:
//  - No pend register; ungranted presses are discarded.
//  - event_drop=1 in the grant cycle if popcount(p)>1.
//  - pending=0.
// TESTING (DB_COUNT=4)
//  1. raw_moneyin[0] held high 20 cycles -> single moneyin[0] pulse after edge 7, 1 cycle wide. No pulse on release. event_drop=0.
//  2. raw_buy[1] toggles every 2 cycles for 12 cycles, then stays high -> exactly one buy[1] pulse, 7 edges after the final rise.
//  3. raw_refund and raw_moneyin[3] rise on same edge -> refund pulses.
//     - EN off: event_drop=1 in the same cycle, no moneyin.
//     - EN on: moneyin[3] pulses next cycle, event_drop=0, pending=1 for 1 cycle.
//  4. raw_buy[0] held high, reset asserted 1 cycle at edge 4 -> no pulse before reset. buy[0] pulse 7 edges after reset drops.
//  5. raw_buy[3] held 100 cycles, low 10, high again -> exactly two buy[3] pulses.
//     Low pulse of 3 cycles mid-hold -> still one pulse.
//  6. EN on, all 9 raw inputs rise together -> 9 consecutive one-cycle pulses in order:
//     refund, moneyin[3..0], buy[3..0]. pending then returns to 0.

Source files
------------

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner
//   Front end for the vending-machine FSM. Each of the 9 raw board inputs passes
//   through a 2-flop synchronizer and a per-channel debouncer. A debounced press
//   (rising edge of the stable level) becomes a one-cycle event. At most one event
//   leaves the block per cycle, chosen by fixed priority.
//
//   Optional feature macro: VM_PENDING_EN
//     defined   : presses that lose arbitration are held in a pend register and
//                 issued later, one per cycle. event_drop flags a re-press of a
//                 channel that is already pending.
//     undefined : presses that lose arbitration are discarded. event_drop flags
//                 the grant cycle whenever more than one press arrived together.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   raw_moneyin  async coin switches   1000[3] 500[2] 200[1] 100[0]
//   raw_buy      async buy buttons     900[3] 700[2] 500[1] 300[0]
//   raw_refund   async refund button
//   moneyin      one-cycle coin event
//   buy          one-cycle buy event
//   refund       one-cycle refund event
//   event_drop   one-cycle flag, a press was discarded or merged
//   pending      high while undelivered presses are queued (0 without VM_PENDING_EN)
//
// Channel vector layout: [8] refund, [7:4] moneyin[3:0], [3:0] buy[3:0].
// Priority descends from bit 8 to bit 0.

module vm_input_conditioner #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_moneyin,
  input  logic [3:0] raw_buy,
  input  logic       raw_refund,
  output logic [3:0] moneyin,
  output logic [3:0] buy,
  output logic       refund,
  output logic       event_drop,
  output logic       pending
);

  localparam int NCH = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCH-1:0] raw_all;
  assign raw_all = {raw_refund, raw_moneyin, raw_buy};

  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] lvl_q, lvl_d;
  logic [NCH-1:0] lvl_dly_q, lvl_dly_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] out_q, out_d;
  logic           drop_q, drop_d;

  logic [NCH-1:0] press;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;

  // Synchronizer: straight flop-to-flop, no logic in between.
  always_comb begin
    sync1_d = raw_all;
    sync2_d = sync1_q;
  end

  // Debounce: the count only advances while the synchronized input disagrees
  // with the accepted level, so any return to the level restarts it.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Press is the rising edge of the debounced level; releases are ignored.
  always_comb begin
    lvl_dly_d = lvl_q;
    press     = lvl_q & ~lvl_dly_q;
  end

`ifdef VM_PENDING_EN
  logic [NCH-1:0] pend_q, pend_d;

  assign req = press | pend_q;
`else
  assign req = press;
`endif

  // Fixed-priority grant, highest set bit wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    out_d = grant;
`ifdef VM_PENDING_EN
    pend_d = req & ~grant;
    // A fresh press on a channel still waiting merges into the pending bit.
    drop_d = |(press & pend_q);
`else
    // More than one simultaneous press: all but the granted one are lost.
    drop_d = |(press & (press - 9'd1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      drop_q    <= 1'b0;
`ifdef VM_PENDING_EN
      pend_q    <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
`ifdef VM_PENDING_EN
      pend_q    <= pend_d;
`endif
    end
  end

  assign refund     = out_q[8];
  assign moneyin    = out_q[7:4];
  assign buy        = out_q[3:0];
  assign event_drop = drop_q;
`ifdef VM_PENDING_EN
  assign pending    = |pend_q;
`else
  assign pending    = 1'b0;
`endif

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Scoreboard bench for vm_input_conditioner with DB_COUNT=4.
// Stimulus pushes expected events (cycle, channel vector, drop, pending) into a
// queue; a negedge monitor pops one entry each time the DUT presents an event.

module tb_vm_input_conditioner;

  logic       clk;
  logic       reset;
  logic [8:0] raw_v;
  logic [3:0] moneyin;
  logic [3:0] buy;
  logic       refund;
  logic       event_drop;
  logic       pending;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
    logic       drop;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  vm_input_conditioner #(.DB_COUNT(4), .CNT_W(19)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_moneyin(raw_v[7:4]),
    .raw_buy    (raw_v[3:0]),
    .raw_refund (raw_v[8]),
    .moneyin    (moneyin),
    .buy        (buy),
    .refund     (refund),
    .event_drop (event_drop),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [8:0] v, input logic d, input logic p);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.drop = d;
    e.pend = p;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle with an event or a drop flag must match the next entry.
  always @(negedge clk) begin
    if (({refund, moneyin, buy} != 9'd0) || event_drop) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h drop=%0b required=none cycle=%0d",
                 {refund, moneyin, buy}, event_drop, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_cycle", cyc, mon_e.cyc);
        chk("ev_vec", {23'd0, refund, moneyin, buy}, {23'd0, mon_e.vec});
        chk("ev_drop", {31'd0, event_drop}, {31'd0, mon_e.drop});
        chk("ev_pending", {31'd0, pending}, {31'd0, mon_e.pend});
      end
    end
  end

  initial begin
    int t;
    clk   = 1'b0;
    reset = 1'b1;
    raw_v = 9'd0;
    step(3);
    chk("reset_out", {21'd0, refund, moneyin, buy, event_drop, pending}, 32'd0);
    reset = 1'b0;
    step(2);
    chk("idle_out", {21'd0, refund, moneyin, buy, event_drop, pending}, 32'd0);

    // 1: coin 100 held 20 cycles, one pulse after edge 7, nothing on release
    raw_v = 9'h010;
    expect_ev(cyc + 7, 9'h010, 1'b0, 1'b0);
    step(20);
    raw_v = 9'h000;
    step(15);
    chk("t1_drained", exp_q.size(), 32'd0);

    // 2: bouncing buy[1], then steady high
    for (int k = 0; k < 3; k++) begin
      raw_v = 9'h002;
      step(2);
      raw_v = 9'h000;
      step(2);
    end
    raw_v = 9'h002;
    expect_ev(cyc + 7, 9'h002, 1'b0, 1'b0);
    step(20);
    raw_v = 9'h000;
    step(15);
    chk("t2_drained", exp_q.size(), 32'd0);

    // 3: refund and coin 1000 together
    raw_v = 9'h180;
    t = cyc;
`ifdef VM_PENDING_EN
    expect_ev(t + 7, 9'h100, 1'b0, 1'b1);
    expect_ev(t + 8, 9'h080, 1'b0, 1'b0);
`else
    expect_ev(t + 7, 9'h100, 1'b1, 1'b0);
`endif
    step(20);
    raw_v = 9'h000;
    step(15);
    chk("t3_drained", exp_q.size(), 32'd0);

    // 4: buy[0] held, reset sampled at edge 4 discards debounce progress
    raw_v = 9'h001;
    t = cyc;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t4_reset_out", {22'd0, refund, moneyin, buy, event_drop}, 32'd0);
    expect_ev(t + 11, 9'h001, 1'b0, 1'b0);
    step(20);
    raw_v = 9'h000;
    step(15);
    chk("t4_drained", exp_q.size(), 32'd0);

    // 5: buy[3] long hold, release, re-press; then a 3-cycle dip mid-hold
    raw_v = 9'h008;
    expect_ev(cyc + 7, 9'h008, 1'b0, 1'b0);
    step(100);
    raw_v = 9'h000;
    step(10);
    raw_v = 9'h008;
    expect_ev(cyc + 7, 9'h008, 1'b0, 1'b0);
    step(30);
    raw_v = 9'h000;
    step(3);
    raw_v = 9'h008;
    step(20);
    raw_v = 9'h000;
    step(15);
    chk("t5_drained", exp_q.size(), 32'd0);

    // 6: all nine inputs at once
    raw_v = 9'h1FF;
    t = cyc;
`ifdef VM_PENDING_EN
    for (int i = 0; i < 9; i++) begin
      logic [8:0] v;
      v = 9'h100 >> i;
      expect_ev(t + 7 + i, v, 1'b0, (i < 8));
    end
`else
    expect_ev(t + 7, 9'h100, 1'b1, 1'b0);
`endif
    step(30);
    raw_v = 9'h000;
    step(15);
    chk("t6_drained", exp_q.size(), 32'd0);
    chk("final_pending", {31'd0, pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
